instr_fetch_unit: RTL and testbench

- Front-end stage that sits directly upstream of the CPU decode/execute stage.
- Owns the program counter and drives the synchronous instruction memory (1-cycle read latency).
- Buffers fetched 19-bit instruction words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects (JMP/BEQ/BNE/CALL/RET targets) from execute, which flush the buffer and restart fetch at the target.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, instruction field positions and opcodes
// Purpose: constants and a predecode helper used by the fetch front-end.
// Ports: none (package).
package cpu_pkg;

  localparam int WORD_W  = 19;
  localparam int IMEM_AW = 10;

  // Instruction fields: opcode, then three operand fields
  localparam int OPC_HI = 18;
  localparam int OPC_LO = 14;
  localparam int FA_HI  = 13;
  localparam int FA_LO  = 10;
  localparam int FB_HI  = 9;
  localparam int FB_LO  = 5;
  localparam int FC_HI  = 4;
  localparam int FC_LO  = 0;

  localparam logic [4:0] OP_JMP  = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b01011;
  localparam logic [4:0] OP_BNE  = 5'b01100;
  localparam logic [4:0] OP_CALL = 5'b01101;
  localparam logic [4:0] OP_RET  = 5'b01110;

  // Control-flow opcodes occupy one contiguous range, JMP through RET
  function automatic logic is_ctrl_op(input logic [4:0] op);
    return (op >= OP_JMP) && (op <= OP_RET);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush and occupancy count
// Purpose: small register-based FIFO; the head entry is read straight out of
//          the storage registers, so there is no path from push data to head.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   push_i/data_i  write an entry (ignored when full)
//   pop_i          remove the head entry (ignored when empty)
//   flush_i        discard all entries; overrides push and pop
//   count_o        number of stored entries, 0..DEPTH
//   head_o         current head entry
module fetch_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != CNT_MAX);
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, instruction memory reader and prefetch buffer
// Purpose: issues reads to a 1-cycle synchronous instruction memory, buffers
//          {pc, instr} pairs and presents them to decode with valid/ready;
//          redirects from execute flush the buffer and restart at the target.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_rd_en, imem_addr      read request to instruction memory
//   imem_rdata                 read data, one cycle after imem_rd_en
//   redirect_valid/pc          single-cycle change-of-flow from execute
//   out_valid/out_ready        handshake towards decode
//   out_instr, out_pc          buffered instruction and its PC
//   out_opcode, out_is_ctrl    predecoded opcode and control-flow flag
module instr_fetch_unit #(
  parameter int WORD_W     = cpu_pkg::WORD_W,
  parameter int IMEM_AW    = cpu_pkg::IMEM_AW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [WORD_W-1:0]  imem_rdata,
  input  logic               redirect_valid,
  input  logic [WORD_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_instr,
  output logic [WORD_W-1:0]  out_pc,
  output logic [4:0]         out_opcode,
  output logic               out_is_ctrl
);

  import cpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * WORD_W;
  localparam logic [CW:0]       DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [WORD_W-1:0] PC_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};

  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              kill_q, kill_d;

  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_head;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;

  // Buffered entries plus the outstanding request act as credits, so a
  // returning response always finds a free slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue     = !reset && !redirect_valid && (occupancy < DEPTH_C);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    kill_d        = redirect_valid;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PC_ONE;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  // A response landing in a redirect cycle, or in the cycle after it,
  // belongs to the old flow and is dropped.
  assign push = inflight_q && !kill_q && !redirect_valid;
  assign pop  = out_valid && out_ready;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({inflight_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc_q[IMEM_AW-1:0];

  // Outputs read as zero whenever the buffer is empty
  assign out_valid   = (fifo_count != '0);
  assign out_pc      = out_valid ? fifo_head[EW-1:WORD_W] : '0;
  assign out_instr   = out_valid ? fifo_head[WORD_W-1:0] : '0;
  assign out_opcode  = out_instr[OPC_HI:OPC_LO];
  assign out_is_ctrl = is_ctrl_op(out_opcode);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [18:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [18:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_instr;
  logic [18:0] out_pc;
  logic [4:0]  out_opcode;
  logic        out_is_ctrl;

  logic [18:0] imem [1024];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .WORD_W     (19),
    .IMEM_AW    (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode),
    .out_is_ctrl    (out_is_ctrl)
  );

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= imem[imem_addr];
  end

  function automatic logic [18:0] exp_word(input logic [18:0] p);
    if (p == 19'd5) return 19'b01101_0011_00000_00000;
    else if (p == 19'd6) return 19'h00000;
    else return p + 19'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  int   n_iss;
  logic stable;

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int k = 0; k < 1024; k++) imem[k] = exp_word(19'(k));
    tick;
    tick;

    check("rst_rd_en",   imem_rd_en,  0);
    check("rst_valid",   out_valid,   0);
    check("rst_instr",   out_instr,   0);
    check("rst_pc",      out_pc,      0);
    check("rst_opcode",  out_opcode,  0);
    check("rst_is_ctrl", out_is_ctrl, 0);

    // Streaming from reset with decode always ready
    out_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check("t1_c1_rd_en", imem_rd_en, 1);
    check("t1_c1_addr",  imem_addr,  0);
    check("t1_c1_valid", out_valid,  0);
    tick;
    check("t1_c2_rd_en", imem_rd_en, 1);
    check("t1_c2_addr",  imem_addr,  1);
    check("t1_c2_valid", out_valid,  0);
    tick;
    check("t1_c3_valid", out_valid, 1);
    check("t1_c3_pc",    out_pc,    0);
    check("t1_c3_instr", out_instr, 19'h100);
    for (int k = 1; k <= 7; k++) begin
      tick;
      check($sformatf("t1_valid%0d", k), out_valid, 1);
      check($sformatf("t1_pc%0d", k),    out_pc,    k);
      check($sformatf("t1_instr%0d", k), out_instr, exp_word(19'(k)));
      if (k == 5) begin
        check("t1_opcode5",  out_opcode,  5'b01101);
        check("t1_is_ctrl5", out_is_ctrl, 1);
      end
      if (k == 6) check("t1_is_ctrl6", out_is_ctrl, 0);
    end

    // Decode stalled: only FIFO_DEPTH reads may be outstanding
    reset     = 1'b1;
    out_ready = 1'b0;
    #1;
    tick;
    reset = 1'b0;
    #1;
    n_iss  = 0;
    stable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (imem_rd_en) begin
        check($sformatf("t2_addr%0d", n_iss), imem_addr, n_iss);
        n_iss++;
      end
      if (c >= 3 && (out_valid !== 1'b1 || out_instr !== 19'h100 || out_pc !== 19'd0)) stable = 1'b0;
      if (c < 10) tick;
    end
    check("t2_issues",      n_iss,      4);
    check("t2_rd_en_idle",  imem_rd_en, 0);
    check("t2_head_stable", stable,     1);
    out_ready = 1'b1;
    #1;
    for (int j = 0; j <= 6; j++) begin
      check($sformatf("t2_drain_valid%0d", j), out_valid, 1);
      check($sformatf("t2_drain_pc%0d", j),    out_pc,    j);
      tick;
    end

    // Redirect with 3 buffered entries and one read outstanding
    reset     = 1'b1;
    out_ready = 1'b0;
    #1;
    tick;
    reset = 1'b0;
    #1;
    repeat (4) tick;
    check("t3_pre_valid", out_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 19'h200;
    #1;
    check("t3_redir_rd_en", imem_rd_en, 0);
    tick;
    redirect_valid = 1'b0;
    #1;
    check("t3_r1_valid", out_valid,  0);
    check("t3_r1_rd_en", imem_rd_en, 1);
    check("t3_r1_addr",  imem_addr,  10'h200);
    out_ready = 1'b1;
    tick;
    check("t3_r2_valid", out_valid, 0);
    tick;
    check("t3_r3_valid", out_valid, 1);
    check("t3_r3_pc",    out_pc,    19'h200);
    check("t3_r3_instr", out_instr, 19'h300);
    tick;
    check("t3_r4_pc", out_pc, 19'h201);

    // Redirect in the same cycle as a handshake
    tick;
    check("t4_pre_pc", out_pc, 19'h202);
    redirect_valid = 1'b1;
    redirect_pc    = 19'h040;
    #1;
    check("t4_hs_valid", out_valid, 1);
    check("t4_hs_pc",    out_pc,    19'h202);
    tick;
    redirect_valid = 1'b0;
    #1;
    check("t4_r1_valid", out_valid,  0);
    check("t4_r1_rd_en", imem_rd_en, 1);
    check("t4_r1_addr",  imem_addr,  10'h040);
    tick;
    check("t4_r2_valid", out_valid, 0);
    tick;
    check("t4_r3_valid", out_valid, 1);
    check("t4_r3_pc",    out_pc,    19'h040);
    check("t4_r3_instr", out_instr, 19'h140);
    tick;
    check("t4_r4_pc", out_pc, 19'h041);

    // Back-to-back redirects: the second target wins
    redirect_valid = 1'b1;
    redirect_pc    = 19'h080;
    #1;
    tick;
    redirect_pc = 19'h090;
    #1;
    check("t5_b1_rd_en", imem_rd_en, 0);
    check("t5_b1_valid", out_valid,  0);
    tick;
    redirect_valid = 1'b0;
    #1;
    check("t5_r1_rd_en", imem_rd_en, 1);
    check("t5_r1_addr",  imem_addr,  10'h090);
    check("t5_r1_valid", out_valid,  0);
    tick;
    check("t5_r2_valid", out_valid, 0);
    tick;
    check("t5_r3_valid", out_valid, 1);
    check("t5_r3_pc",    out_pc,    19'h090);
    check("t5_r3_instr", out_instr, 19'h190);

    // Reset in the middle of the stream with a read outstanding
    check("t6_pre_rd_en", imem_rd_en, 1);
    tick;
    reset = 1'b1;
    #1;
    check("t6_rst_valid",  out_valid,  0);
    check("t6_rst_pc",     out_pc,     0);
    check("t6_rst_instr",  out_instr,  0);
    check("t6_rst_opcode", out_opcode, 0);
    check("t6_rst_rd_en",  imem_rd_en, 0);
    tick;
    reset = 1'b0;
    #1;
    check("t6_c1_rd_en", imem_rd_en, 1);
    check("t6_c1_addr",  imem_addr,  0);
    check("t6_c1_valid", out_valid,  0);
    tick;
    check("t6_c2_valid", out_valid, 0);
    tick;
    check("t6_c3_valid", out_valid, 1);
    check("t6_c3_pc",    out_pc,    0);
    check("t6_c3_instr", out_instr, 19'h100);
    tick;
    check("t6_c4_pc", out_pc, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
